// File: rtl/amstrad_mem_arbiter.sv
// amstrad_mem_arbiter: single-port scheduler in front of the SDRAM/ROM backend.
// Serves video fetch (16-bit read), Z80 cycles (8-bit r/w) and the ROM/disk
// loader (8-bit writes) one transaction at a time over a req/ack handshake.
// Fixed priority vid > cpu > ldr, with a starvation override for the loader.
// Optional build macro ARB_STATS_EN adds saturating per-requester completion
// counters (stat_vid/stat_cpu/stat_ldr) and a stat_clr input.
module amstrad_mem_arbiter #(
  parameter int unsigned        ADDR_W     = 23,
  parameter logic [ADDR_W-1:0]  VID_BASE   = '0,
  parameter int unsigned        STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [14:0]       vid_addr,
  output logic [15:0]       vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              cpu_busy,
  input  logic              ldr_wr,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_data,
  output logic              ldr_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_16,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_vid,
  output logic [15:0]       stat_cpu,
  output logic [15:0]       stat_ldr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_VID, S_CPU, S_LDR} state_t;

  localparam int unsigned     CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t             r_state, w_state_nxt;
  logic               w_gnt_vid, w_gnt_cpu, w_gnt_ldr;
  logic               w_done_vid, w_done_cpu, w_done_ldr;

  logic               r_vid_pend, r_vid_overrun;
  logic [14:0]        r_vid_addr;

  logic               w_cpu_strb, w_cpu_rise;
  logic               r_cpu_strb_d, r_cpu_pend, r_cpu_busy, r_cpu_we;
  logic [ADDR_W-1:0]  r_cpu_addr;
  logic [7:0]         r_cpu_wdata;

  logic               w_ldr_busy;
  logic               r_ldr_pend, r_ldr_arm;
  logic [ADDR_W-1:0]  r_ldr_addr;
  logic [7:0]         r_ldr_wdata;

  logic [CNT_W-1:0]   r_starve_cnt;

  logic               r_mem_we, r_mem_16;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [7:0]         r_mem_wdata;

  logic [15:0]        r_vid_data;
  logic               r_vid_valid, r_ldr_ack;
  logic [7:0]         r_cpu_din;

  assign w_done_vid = mem_ack && (r_state == S_VID);
  assign w_done_cpu = mem_ack && (r_state == S_CPU);
  assign w_done_ldr = mem_ack && (r_state == S_LDR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant selection in IDLE, wait for backend ack in the busy states
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_vid   = 1'b0;
    w_gnt_cpu   = 1'b0;
    w_gnt_ldr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ldr_pend && (r_starve_cnt == STARVE_LIM)) begin
          w_state_nxt = S_LDR;
          w_gnt_ldr   = 1'b1;
        end else if (r_vid_pend) begin
          w_state_nxt = S_VID;
          w_gnt_vid   = 1'b1;
        end else if (r_cpu_pend) begin
          w_state_nxt = S_CPU;
          w_gnt_cpu   = 1'b1;
        end else if (r_ldr_pend) begin
          w_state_nxt = S_LDR;
          w_gnt_ldr   = 1'b1;
        end
      end
      S_VID, S_CPU, S_LDR: begin
        if (mem_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Video request slot: pend clears at grant so a same-cycle request refills it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vid_pend    <= 1'b0;
      r_vid_addr    <= '0;
      r_vid_overrun <= 1'b0;
    end else if (vid_req) begin
      r_vid_pend <= 1'b1;
      r_vid_addr <= vid_addr;
      if (r_vid_pend && !w_gnt_vid) r_vid_overrun <= 1'b1;
    end else if (w_gnt_vid) begin
      r_vid_pend <= 1'b0;
    end
  end

  assign w_cpu_strb = cpu_rd | cpu_wr;
  assign w_cpu_rise = w_cpu_strb & ~r_cpu_strb_d;

  // CPU capture on strobe rising edge; busy holds until the backend completes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_strb_d <= 1'b0;
      r_cpu_pend   <= 1'b0;
      r_cpu_busy   <= 1'b0;
      r_cpu_we     <= 1'b0;
      r_cpu_addr   <= '0;
      r_cpu_wdata  <= '0;
    end else begin
      r_cpu_strb_d <= w_cpu_strb;
      if (w_cpu_rise && !r_cpu_busy) begin
        r_cpu_pend  <= 1'b1;
        r_cpu_busy  <= 1'b1;
        r_cpu_we    <= cpu_wr;
        r_cpu_addr  <= cpu_addr;
        r_cpu_wdata <= cpu_dout;
      end else begin
        if (w_gnt_cpu)  r_cpu_pend <= 1'b0;
        if (w_done_cpu) r_cpu_busy <= 1'b0;
      end
    end
  end

  assign w_ldr_busy = r_ldr_pend | (r_state == S_LDR);

  // Loader capture; re-arms only after a cycle with ldr_wr low while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ldr_pend  <= 1'b0;
      r_ldr_arm   <= 1'b1;
      r_ldr_addr  <= '0;
      r_ldr_wdata <= '0;
    end else if (ldr_wr && r_ldr_arm && !w_ldr_busy) begin
      r_ldr_pend  <= 1'b1;
      r_ldr_arm   <= 1'b0;
      r_ldr_addr  <= ldr_addr;
      r_ldr_wdata <= ldr_data;
    end else begin
      if (w_gnt_ldr)               r_ldr_pend <= 1'b0;
      if (!ldr_wr && !w_ldr_busy)  r_ldr_arm  <= 1'b1;
    end
  end

  // Starvation counter: counts higher-priority grants the loader waited through
  always_ff @(posedge clk) begin
    if (reset || w_gnt_ldr) begin
      r_starve_cnt <= '0;
    end else if ((w_gnt_vid || w_gnt_cpu) && r_ldr_pend && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // Backend command registers, loaded on grant and held until the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_we    <= 1'b0;
      r_mem_16    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_gnt_vid) begin
      r_mem_we    <= 1'b0;
      r_mem_16    <= 1'b1;
      r_mem_addr  <= VID_BASE + ADDR_W'({r_vid_addr, 1'b0});
      r_mem_wdata <= '0;
    end else if (w_gnt_cpu) begin
      r_mem_we    <= r_cpu_we;
      r_mem_16    <= 1'b0;
      r_mem_addr  <= r_cpu_addr;
      r_mem_wdata <= r_cpu_wdata;
    end else if (w_gnt_ldr) begin
      r_mem_we    <= 1'b1;
      r_mem_16    <= 1'b0;
      r_mem_addr  <= r_ldr_addr;
      r_mem_wdata <= r_ldr_wdata;
    end
  end

  // Return data and completion pulses to the owning requester
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
      r_cpu_din   <= '0;
      r_ldr_ack   <= 1'b0;
    end else begin
      r_vid_valid <= w_done_vid;
      r_ldr_ack   <= w_done_ldr;
      if (w_done_vid)              r_vid_data <= mem_rdata;
      if (w_done_cpu && !r_mem_we) r_cpu_din  <= mem_rdata[7:0];
    end
  end

  assign mem_req     = (r_state != S_IDLE);
  assign mem_we      = r_mem_we;
  assign mem_16      = r_mem_16;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign vid_data    = r_vid_data;
  assign vid_valid   = r_vid_valid;
  assign vid_overrun = r_vid_overrun;
  assign cpu_din     = r_cpu_din;
  assign cpu_busy    = r_cpu_busy;
  assign ldr_ack     = r_ldr_ack;

`ifdef ARB_STATS_EN
  logic [15:0] r_stat_vid, r_stat_cpu, r_stat_ldr;

  // Completion counters; clear dominates, counts saturate at all-ones
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      r_stat_vid <= '0;
      r_stat_cpu <= '0;
      r_stat_ldr <= '0;
    end else begin
      if (w_done_vid && (r_stat_vid != '1)) r_stat_vid <= r_stat_vid + 16'd1;
      if (w_done_cpu && (r_stat_cpu != '1)) r_stat_cpu <= r_stat_cpu + 16'd1;
      if (w_done_ldr && (r_stat_ldr != '1)) r_stat_ldr <= r_stat_ldr + 16'd1;
    end
  end

  assign stat_vid = r_stat_vid;
  assign stat_cpu = r_stat_cpu;
  assign stat_ldr = r_stat_ldr;
`endif

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Scoreboard bench for amstrad_mem_arbiter: expected backend transactions,
// video words and CPU read data are queued when stimulus is driven and
// popped when the DUT issues / completes them.
module tb_amstrad_mem_arbiter;

  localparam int unsigned ADDR_W = 23;

  logic              clk;
  logic              reset;
  logic              vid_req;
  logic [14:0]       vid_addr;
  logic [15:0]       vid_data;
  logic              vid_valid;
  logic              vid_overrun;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_dout;
  logic [7:0]        cpu_din;
  logic              cpu_busy;
  logic              ldr_wr;
  logic [ADDR_W-1:0] ldr_addr;
  logic [7:0]        ldr_data;
  logic              ldr_ack;
  logic              mem_req;
  logic              mem_we;
  logic              mem_16;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  amstrad_mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .VID_BASE  (23'h000000),
    .STARVE_MAX(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid),
    .vid_overrun(vid_overrun),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_busy   (cpu_busy),
    .ldr_wr     (ldr_wr),
    .ldr_addr   (ldr_addr),
    .ldr_data   (ldr_data),
    .ldr_ack    (ldr_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_16     (mem_16),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        we;
    logic        w16;
    logic [22:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  txn_t        exp_txn[$];
  logic [15:0] exp_vid[$];
  logic [7:0]  exp_din[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk_txn(input logic we, input logic w16,
                                  input logic [22:0] addr, input logic [7:0] wdata);
    txn_t t;
    t.we = we; t.w16 = w16; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  // Backend model: fixed latency ack, checks each issued command against the scoreboard
  int          bk_lat = 3;
  logic [15:0] bk_rdata = 16'h0000;
  int          bk_ntxn = 0;
  int          stray_req_n = 0;
  int          stray_done_n = 0;

  initial begin : backend
    bit   active;
    int   cnt;
    txn_t cur, e;
    active = 0;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (reset) begin
        active = 0;
      end else if (active) begin
        chk("mem_held", {mem_req, mem_we, mem_16, mem_addr, mem_wdata}, {1'b1, cur});
        cnt++;
        if (cnt >= bk_lat) begin
          mem_ack = 1'b1;
          mem_rdata = bk_rdata;
          active = 0;
        end
      end else if (mem_req) begin
        cur = mk_txn(mem_we, mem_16, mem_addr, mem_wdata);
        active = 1;
        cnt = 0;
        bk_ntxn++;
        chk("txn_expected", exp_txn.size() != 0, 1);
        if (exp_txn.size() != 0) begin
          e = exp_txn.pop_front();
          chk("txn_we", cur.we, e.we);
          chk("txn_16", cur.w16, e.w16);
          chk("txn_addr", cur.addr, e.addr);
          if (e.we) chk("txn_wdata", cur.wdata, e.wdata);
        end
      end else if (stray_req_n != stray_done_n) begin
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        stray_done_n++;
      end
    end
  end

  // Output monitor: pops expected video words and CPU completion data
  int   n_vv = 0;
  int   n_la = 0;
  logic busy_q = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (vid_valid) begin
          n_vv++;
          chk("vid_valid_expected", exp_vid.size() != 0, 1);
          if (exp_vid.size() != 0) chk("vid_data", vid_data, exp_vid.pop_front());
        end
        if (ldr_ack) n_la++;
        if (busy_q && !cpu_busy) begin
          chk("cpu_done_expected", exp_din.size() != 0, 1);
          if (exp_din.size() != 0) chk("cpu_din", cpu_din, exp_din.pop_front());
        end
      end
      busy_q = cpu_busy;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_vid(input logic [14:0] a);
    vid_req = 1'b1;
    vid_addr = a;
    tick();
    vid_req = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (exp_txn.size() == 0) && (exp_vid.size() == 0) && (exp_din.size() == 0)
             && !mem_req && !cpu_busy;
    end
    chk({tag, "_drain"}, done, 1);
  endtask

  int n0;
  int nv0;
  int la0;

  initial begin : main
    reset = 1'b1;
    vid_req = 1'b0; vid_addr = '0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_dout = '0;
    ldr_wr = 1'b0; ldr_addr = '0; ldr_data = '0;
    repeat (3) tick();
    chk("reset_outs", {vid_data, vid_valid, vid_overrun, cpu_din, cpu_busy, ldr_ack,
                       mem_req, mem_we, mem_16, mem_addr, mem_wdata}, 64'h0);
    reset = 1'b0;
    tick();

    // Single video fetch, ack 3 clk after mem_req
    bk_lat = 3; bk_rdata = 16'hA55A;
    exp_txn.push_back(mk_txn(1'b0, 1'b1, 23'h000468, 8'h00));
    exp_vid.push_back(16'hA55A);
    nv0 = n_vv;
    pulse_vid(15'h234);
    chk("t1_req_lat1", mem_req, 0);
    tick();
    chk("t1_req_lat2", mem_req, 1);
    chk("t1_addr", mem_addr, 23'h000468);
    chk("t1_16", mem_16, 1);
    wait_drain("t1", 40);
    chk("t1_valid_pulses", n_vv - nv0, 1);

    // CPU read and video in the same clk: video first, busy spans both
    bk_lat = 2; bk_rdata = 16'h003C;
    exp_txn.push_back(mk_txn(1'b0, 1'b1, 23'h000020, 8'h00));
    exp_txn.push_back(mk_txn(1'b0, 1'b0, 23'h001234, 8'h00));
    exp_vid.push_back(16'h003C);
    exp_din.push_back(8'h3C);
    cpu_addr = 23'h001234; cpu_dout = 8'h00;
    vid_req = 1'b1; vid_addr = 15'h010; cpu_rd = 1'b1;
    tick();
    vid_req = 1'b0;
    chk("t2_busy_start", cpu_busy, 1);
    for (int i = 0; i < 30 && !vid_valid; i++) tick();
    chk("t2_vid_done_busy", {vid_valid, cpu_busy}, 2'b11);
    wait_drain("t2", 40);
    cpu_rd = 1'b0;
    tick();
    chk("t2_cpu_din", cpu_din, 8'h3C);

    // Held write strobe must produce exactly one transaction
    bk_lat = 2;
    n0 = bk_ntxn;
    exp_txn.push_back(mk_txn(1'b1, 1'b0, 23'h004000, 8'h77));
    exp_din.push_back(8'h3C);
    cpu_addr = 23'h004000; cpu_dout = 8'h77; cpu_wr = 1'b1;
    repeat (12) tick();
    cpu_wr = 1'b0;
    wait_drain("t3", 40);
    chk("t3_txn_count", bk_ntxn - n0, 1);

    // Two video requests while a CPU read is in flight: second wins, overrun sticks
    bk_lat = 6; bk_rdata = 16'h5A81;
    exp_txn.push_back(mk_txn(1'b0, 1'b0, 23'h002222, 8'h00));
    exp_txn.push_back(mk_txn(1'b0, 1'b1, 23'h000202, 8'h00));
    exp_din.push_back(8'h81);
    exp_vid.push_back(16'h5A81);
    cpu_addr = 23'h002222; cpu_dout = 8'h00; cpu_rd = 1'b1;
    tick();
    tick();
    chk("t4_cpu_inflight", {mem_req, mem_16}, 2'b10);
    vid_req = 1'b1; vid_addr = 15'h100;
    tick();
    vid_addr = 15'h101;
    tick();
    vid_req = 1'b0;
    chk("t4_overrun", vid_overrun, 1);
    wait_drain("t4", 60);
    cpu_rd = 1'b0;
    repeat (5) tick();
    chk("t4_overrun_sticky", vid_overrun, 1);

    // Loader held against continuous video: forced after exactly 8 video grants
    bk_lat = 3; bk_rdata = 16'h1111;
    n0 = bk_ntxn; la0 = n_la;
    for (int k = 0; k < 8; k++)
      exp_txn.push_back(mk_txn(1'b0, 1'b1, {7'd0, 15'(15'h300 + k), 1'b0}, 8'h00));
    exp_txn.push_back(mk_txn(1'b1, 1'b0, 23'h07F000, 8'hE1));
    exp_txn.push_back(mk_txn(1'b0, 1'b1, {7'd0, 15'h308, 1'b0}, 8'h00));
    for (int k = 0; k < 9; k++) exp_vid.push_back(16'h1111);
    ldr_addr = 23'h07F000; ldr_data = 8'hE1; ldr_wr = 1'b1;
    pulse_vid(15'h300);
    for (int k = 1; k <= 8; k++) begin
      for (int i = 0; i < 40 && bk_ntxn < n0 + k; i++) tick();
      chk("t5_txn_started", bk_ntxn >= n0 + k, 1);
      pulse_vid(15'(15'h300 + k));
    end
    for (int i = 0; i < 60 && !ldr_ack; i++) tick();
    chk("t5_ldr_ack_seen", ldr_ack, 1);
    tick();
    ldr_wr = 1'b0;
    wait_drain("t5", 80);
    chk("t5_ldr_ack_count", n_la - la0, 1);

    // Reset mid-transaction, then a stray ack
    bk_lat = 20;
    exp_txn.push_back(mk_txn(1'b0, 1'b1, 23'h0000AA, 8'h00));
    pulse_vid(15'h055);
    tick();
    tick();
    chk("t6_req_before_reset", mem_req, 1);
    reset = 1'b1;
    tick();
    chk("t6_reset_outs", {vid_data, vid_valid, vid_overrun, cpu_din, cpu_busy, ldr_ack,
                          mem_req, mem_we, mem_16, mem_addr, mem_wdata}, 64'h0);
    tick();
    reset = 1'b0;
    nv0 = n_vv; la0 = n_la;
    stray_req_n++;
    repeat (4) tick();
    chk("t6_stray_consumed", stray_done_n, stray_req_n);
    chk("t6_stray_vid_valid", n_vv - nv0, 0);
    chk("t6_stray_ldr_ack", n_la - la0, 0);
    chk("t6_stray_cpu_din", cpu_din, 8'h00);
    chk("t6_stray_mem_req", mem_req, 0);

    chk("sb_empty", exp_txn.size() + exp_vid.size() + exp_din.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/amstrad_mem_arbiter.md
Name: amstrad_mem_arbiter

Overview:
- Single-port memory scheduler between the motherboard and the external RAM/ROM controller (SDRAM backend).
- Arbitrates three requesters:
  - video fetch: 16-bit reads, hard real-time;
  - Z80 memory cycles: 8-bit read/write, level-held strobes;
  - ROM/disk loader: 8-bit writes, bulk, latency-tolerant.
- Issues one backend transaction at a time using a req/ack handshake, and returns data to the requester that owns the transaction.

Parameters:
- ADDR_W, 23, backend byte address width.
- VID_BASE, 23'h000000, base byte address added to the video word address.
- STARVE_MAX, 8, number of consecutive non-loader grants allowed while the loader is pending before the loader is forced next.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vid_req  in  1  one-cycle pulse: fetch the 16-bit word at vid_addr
- vid_addr  in  15  video word address
- vid_data  out  16  fetched video word
- vid_valid  out  1  one-cycle pulse when vid_data is updated
- vid_overrun  out  1  sticky flag: a vid_req was dropped or overwritten
- cpu_rd  in  1  Z80 memory read strobe, level, held for several clk
- cpu_wr  in  1  Z80 memory write strobe, level
- cpu_addr  in  ADDR_W  mapped CPU address
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  CPU read data, held until the next CPU read completes
- cpu_busy  out  1  CPU access accepted but not yet completed (drives wait)
- ldr_wr  in  1  loader write request, level; held until ldr_ack
- ldr_addr  in  ADDR_W  loader address
- ldr_data  in  8  loader data
- ldr_ack  out  1  one-cycle pulse: loader write completed
- mem_req  out  1  backend request, held until mem_ack
- mem_we  out  1  write enable, qualified by mem_req
- mem_16  out  1  16-bit read (video transaction)
- mem_addr  out  ADDR_W  backend address
- mem_wdata  out  8  backend write data
- mem_rdata  in  16  backend read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset values:
  - all outputs 0: mem_req, mem_we, mem_16, mem_addr, mem_wdata, vid_data, vid_valid, vid_overrun, cpu_din, cpu_busy, ldr_ack;
  - pending latches cleared; starvation counter 0; FSM in IDLE.
- Request capture, evaluated every clk independent of FSM state:
  - vid: vid_req sets vid_pend and latches vid_addr.
    - vid_req while vid_pend is already set: latch the new address and set vid_overrun.
    - vid_req in the same cycle the pending video transaction is granted: goes into the empty slot; no overrun.
  - cpu: a rising edge of (cpu_rd|cpu_wr) sets cpu_pend and latches addr, data and direction. cpu_busy is asserted from the next clk.
    - A held level never re-triggers.
    - Strobe deasserting before completion does not cancel the access.
  - ldr: ldr_wr level. Re-arms only after ldr_ack plus one cycle of ldr_wr low or a new cycle. The loader must drop ldr_wr in the cycle after ldr_ack.
- FSM states: IDLE, VID, CPU, LDR.
  - IDLE: when any requester is pending, select the grant, drive the mem_* outputs and mem_req=1 in the next clk.
  - Priority: vid > cpu > ldr.
  - Exception: if ldr is pending and starve_cnt == STARVE_MAX, ldr wins over everything.
  - Starvation counter: increments on each vid/cpu grant while ldr is pending; clears on an ldr grant.
- VID / CPU / LDR states: hold mem_req and all mem_* outputs stable until mem_ack.
  - On mem_ack: mem_req=0, return to IDLE. Back-to-back issue is allowed, i.e. a new mem_req can assert the clk after IDLE.
  - Minimum gap between requests: 1 clk with mem_req low.
- Video address: mem_addr = VID_BASE + {vid_addr,1'b0}; mem_16 = 1; mem_we = 0.
- Completion:
  - VID: vid_data <= mem_rdata, vid_valid pulses 1 clk, vid_pend clears.
  - CPU read: cpu_din <= mem_rdata[7:0].
  - CPU any direction: cpu_busy drops in the clk after mem_ack.
  - LDR: ldr_ack pulses 1 clk.
- mem_ack outside VID/CPU/LDR (e.g. straggler after reset): ignored.
- Reset mid-transaction: everything returns to reset values immediately. The backend shares the same reset.
- Latency from an idle arbiter: request capture 1 clk + grant 1 clk + backend latency, so mem_req asserts 2 clk after the request.

Optional Feature:
- ARB_STATS_EN: adds outputs stat_vid, stat_cpu, stat_ldr (16-bit each) and stat_clr (in, 1).
  - Each counter increments on completion of its requester's transaction.
  - Counters saturate at 16'hFFFF.
  - Counters are cleared by reset or by stat_clr; stat_clr wins over a simultaneous increment.
- Without the macro these ports are absent and no counter logic exists.

Test Plan:
- Video read, backend ack after 3 clk, mem_rdata=16'hA55A:
  - mem_req asserts with mem_addr=23'h00468 (vid_addr=15'h234, VID_BASE=0) and mem_16=1;
  - vid_data=16'hA55A with a single vid_valid pulse.
- cpu_rd and vid_req rise in the same clk:
  - video is served first, then CPU;
  - cpu_busy stays 1 through both transactions;
  - cpu_din=8'h3C after the CPU ack (mem_rdata=16'h003C).
- cpu_wr held for 12 clk, addr 23'h4000, data 8'h77: exactly one transaction with mem_we=1, mem_wdata=8'h77; no retrigger.
- ldr_wr held while video requests arrive continuously, STARVE_MAX=8: the loader is granted after exactly 8 video grants; ldr_ack pulses once.
- Two vid_req 1 clk apart while a CPU access is in flight:
  - the second address is the one fetched;
  - vid_overrun=1 and stays 1 until reset.
- reset asserted while mem_req=1, then a stray mem_ack:
  - all outputs are 0 the next clk;
  - the stray ack causes no vid_valid, ldr_ack or cpu_din change.
